// File: rtl/wb_slave_regs.sv
// wb_slave_regs: Wishbone classic responder with a CSR, a 4-deep byte FIFO,
// a scratch register and a status register. Wait states are programmable
// through CSR.WS; every output is driven straight from a flop.
module wb_slave_regs #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
  output logic                  irq_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_DONE} state_t;

  state_t      r_state, w_nextState;
  logic [2:0]  r_cnt, w_nextCnt;
  logic        w_commit;

  logic [1:0]  r_adr;
  logic        r_we;
  logic [7:0]  r_wdat;

  logic        r_ack;
  logic [7:0]  r_dat;
  logic        r_irq;

  logic        r_ie;
  logic [2:0]  r_ws;
  logic [7:0]  r_scratch;

  logic [7:0]  r_fifo [4];
  logic [1:0]  r_rdPtr, r_wrPtr;
  logic [2:0]  r_count;
  logic        r_ovf, r_unf;

  logic        w_req, w_inIdle, w_full, w_empty, w_push;
  logic [1:0]  w_cAdr;
  logic        w_cWe;
  logic [7:0]  w_cWdat, w_rdData, w_stat;

  assign w_req    = cyc_i & stb_i;
  assign w_inIdle = (r_state == S_IDLE);
  // With zero wait states the commit happens on the accepting edge, so the
  // live bus fields are used there; later commits use the latched copy.
  assign w_cAdr   = w_inIdle ? adr_i[1:0] : r_adr;
  assign w_cWe    = w_inIdle ? we_i       : r_we;
  assign w_cWdat  = w_inIdle ? dat_i[7:0] : r_wdat;

  assign w_full   = (r_count == 3'd4);
  assign w_empty  = (r_count == 3'd0);
  assign w_stat   = {1'b0, r_count, r_unf, r_ovf, w_full, w_empty};
  assign w_push   = w_commit & w_cWe & (w_cAdr == 2'd1) & ~w_full;

  assign dat_o = r_dat;
  assign ack_o = r_ack;
  assign irq_o = r_irq;

  // Next-state logic; w_commit marks the edge that enters ACK.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (r_ws != 3'd0) begin
            w_nextState = S_WAIT;
            w_nextCnt   = r_ws;
          end else begin
            w_nextState = S_ACK;
            w_commit    = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!w_req) begin
          w_nextState = S_IDLE;
        end else if (r_cnt == 3'd1) begin
          w_nextState = S_ACK;
          w_commit    = 1'b1;
        end else begin
          w_nextCnt = r_cnt - 3'd1;
        end
      end
      S_ACK: begin
        w_nextState = S_DONE;
      end
      S_DONE: begin
        if (!w_req) w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Read-data selection for the register being addressed.
  always_comb begin
    w_rdData = 8'h00;
    case (w_cAdr)
      2'd0: w_rdData = {r_ie, 4'b0000, r_ws};
      2'd1: w_rdData = w_empty ? 8'h00 : r_fifo[r_rdPtr];
      2'd2: w_rdData = r_scratch;
      2'd3: w_rdData = w_stat;
      default: w_rdData = 8'h00;
    endcase
  end

  // FSM state and wait-state counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  // Capture the request fields when a transfer is accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_adr  <= 2'd0;
      r_we   <= 1'b0;
      r_wdat <= 8'h00;
    end else if (w_inIdle && w_req) begin
      r_adr  <= adr_i[1:0];
      r_we   <= we_i;
      r_wdat <= dat_i[7:0];
    end
  end

  // Registered bus outputs: one-cycle ack, read data only alongside ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack <= 1'b0;
      r_dat <= 8'h00;
      r_irq <= 1'b0;
    end else begin
      r_ack <= w_commit;
      r_dat <= (w_commit && !w_cWe) ? w_rdData : 8'h00;
      r_irq <= r_ie & ~w_empty;
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wrPtr] <= w_cWdat;
  end

  // Register file, FIFO bookkeeping and sticky flags, all committed on ACK entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ie      <= 1'b0;
      r_ws      <= 3'd0;
      r_scratch <= 8'h00;
      r_rdPtr   <= 2'd0;
      r_wrPtr   <= 2'd0;
      r_count   <= 3'd0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else if (w_commit) begin
      if (w_cWe) begin
        case (w_cAdr)
          2'd0: begin
            r_ie <= w_cWdat[7];
            r_ws <= w_cWdat[2:0];
            if (w_cWdat[6]) begin
              r_rdPtr <= 2'd0;
              r_wrPtr <= 2'd0;
              r_count <= 3'd0;
              r_ovf   <= 1'b0;
              r_unf   <= 1'b0;
            end
          end
          2'd1: begin
            if (w_full) begin
              r_ovf <= 1'b1;
            end else begin
              r_wrPtr <= r_wrPtr + 2'd1;
              r_count <= r_count + 3'd1;
            end
          end
          2'd2: r_scratch <= w_cWdat;
          default: ;
        endcase
      end else begin
        case (w_cAdr)
          2'd1: begin
            if (w_empty) begin
              r_unf <= 1'b1;
            end else begin
              r_rdPtr <= r_rdPtr + 2'd1;
              r_count <= r_count - 3'd1;
            end
          end
          2'd3: begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
